// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  // Squashed IF/ID slot carrying the pipeline's bubble instruction.
  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop_instr);
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.instr = nop_instr;
    b.pc4   = '0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t entry_i,
  output if_id_t entry_o
);

  if_id_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (bubble_i) begin
      entry_d = if_id_bubble(NOP_INSTR);
    end else if (load_i) begin
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry_q <= if_id_bubble(NOP_INSTR);
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect/stall/flush handling, IF/ID register.
// Optional MISALIGN_TRAP_EN: misaligned redirects are dropped and flagged on misalign_o.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [XLEN-1:0] fetch_count_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_take;
  logic            ifid_bubble;
  logic            ifid_load;
  if_id_t          ifid_entry;
  if_id_t          ifid_q;

  assign pc_plus4     = pc_q + XLEN'(4);
  assign redirect_tgt = redirect_pc_i & ~XLEN'(3);

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic redirect_misaligned;

  // A misaligned target is refused: PC stays put, only the trap flag moves.
  assign redirect_misaligned = |redirect_pc_i[1:0];
  assign redirect_take       = redirect_i && !redirect_misaligned;
  assign misalign_d          = redirect_i && redirect_misaligned;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign redirect_take = redirect_i;
`endif

  // Next PC: redirect over stall over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_take) begin
      pc_d = redirect_tgt;
    end else if (!redirect_i && !stall_i) begin
      pc_d = pc_plus4;
    end
  end

  assign ifid_bubble = redirect_i || flush_i;
  assign ifid_load   = !stall_i;

  always_comb begin
    count_d = count_q;
    if (ifid_load && !ifid_bubble) begin
      count_d = count_q + XLEN'(1);
    end
  end

  always_comb begin
    ifid_entry       = '0;
    ifid_entry.valid = 1'b1;
    ifid_entry.pc    = pc_q;
    ifid_entry.instr = imem_instr_i;
    ifid_entry.pc4   = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .entry_i  (ifid_entry),
    .entry_o  (ifid_q)
  );

  assign imem_addr_o   = pc_q;
  assign ifid_valid_o  = ifid_q.valid;
  assign ifid_pc_o     = ifid_q.pc;
  assign ifid_instr_o  = ifid_q.instr;
  assign ifid_pc4_o    = ifid_q.pc4;
  assign fetch_count_o = count_q;

endmodule
